output_accum_pipe: RTL and testbench
====================================

// Module: output_accum_pipe
// PURPOSE
//  Parametrised output pipeline: fetches NUM_PORTS scratchpad words per cycle, reduces all lanes
//  into signed accumulators, packs LANES finished results per output word, writes output memory.
//  Replaces the fixed two-port/128-bit fetch+store path; adds configurable length, saturation, partial flush.
// PARAMETERS
//  DATA_W    16  lane width (signed two's complement), also result width
//  LANES     8   lanes per scratchpad/output word
//  NUM_PORTS 2   scratchpad read ports fetched in parallel
//  ADDR_W    16  address width, all ports
//  LEN_W     8   width of cfg_len / cfg_count
//  SAT       1   1: saturate result to DATA_W; 0: truncate (wrap)
// PORTS
//  clock         in   1                      rising-edge clock
//  reset_n       in   1                      async active-low reset
//  start         in   1                      1-cycle request, sampled only in IDLE
//  cfg_len       in   LEN_W                  words per port summed into one result
//  cfg_count     in   LEN_W                  number of results to produce
//  cfg_rd_base   in   NUM_PORTS*ADDR_W       read base per port (port p at [p*ADDR_W +: ADDR_W])
//  cfg_out_base  in   ADDR_W                 first output address
//  sp_read_en    out  1                      read strobe, data returns next cycle
//  sp_read_addr  out  NUM_PORTS*ADDR_W       read address per port
//  sp_read_bus   in   NUM_PORTS*LANES*DATA_W read data, lane l of port p at [(p*LANES+l)*DATA_W +: DATA_W]
//  out_we        out  1                      output write strobe, 1 cycle per word
//  out_bus       out  LANES*DATA_W           packed results, result k of word at lane k
//  out_addr      out  ADDR_W                 output address
//  busy          out  1                      high from cycle after accepted start until done
//  done          out  1                      1-cycle pulse at end of job
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, accumulators/counters/pack register cleared; mid-job reset aborts silently.
//  Config latched on accepted start; inputs may change afterward. start while busy ignored.
//  States: IDLE -> FETCH -> DRAIN -> FLUSH -> IDLE.
//   IDLE: start & cfg_len!=0 & cfg_count!=0 -> FETCH, busy=1. Either zero -> done pulse next cycle, no reads/writes.
//   FETCH: sp_read_en=1 every cycle; issue index i=0..cfg_len*cfg_count-1; port p addr = rd_base[p]+i mod 2^ADDR_W.
//     After last issue -> DRAIN.
//   DRAIN: one cycle, consumes final returned data. -> FLUSH.
//   FLUSH: if pack count>0 write partial word (unused lanes 0); then done=1, busy=0 -> IDLE (same cycle as done).
//  Accumulate (cycle after each read): term = sign-extended sum of all NUM_PORTS*LANES lanes;
//   acc = (first word of result ? 0 : acc) + term; internal width DATA_W+clog2(NUM_PORTS*LANES)+LEN_W, no overflow.
//  On last word of a result: value = SAT ? clamp(acc, -2^(DATA_W-1), 2^(DATA_W-1)-1) : acc[DATA_W-1:0];
//   stored into pack lane store_cnt, store_cnt++.
//  Pack full (store_cnt reaches LANES): out_we=1 next cycle with packed word, out_addr=cfg_out_base+words_written;
//   store_cnt=0, lanes cleared. Final result that fills a word: single write, no extra FLUSH write.
//  Write latency: out_we one cycle after the data cycle holding the last word of the LANES-th result.
//  out_bus/out_addr hold last written value while out_we=0. Output addresses wrap mod 2^ADDR_W.
//  Throughput: one read per cycle per port, no stalls; total job = 1 + L*C + 1 + 1(+1 partial) cycles.
// TESTING
//  1. Defaults, len=1,count=8, all lanes =1 -> 8 reads, one write at out_base, every lane = 16, done once.
//  2. len=4,count=3, lanes=1 -> 12 reads, addresses base..base+11; one partial write lanes0-2=64, lanes3-7=0.
//  3. SAT=1, all lanes 0x7FFF, len=2 -> result 0x7FFF; all lanes 0x8000 -> 0x8000; SAT=0 case -> truncated low bits.
//  4. cfg_count=0 start -> done pulse next cycle, sp_read_en and out_we never asserted.
//  5. start pulses during busy + reset_n low mid-FETCH -> ignored starts; after reset all outputs 0, IDLE.
//  6. rd_base=0xFFFE, count=16 -> read addresses wrap to 0x0000; two full writes at out_base, out_base+1.

Source files
------------

// File: rtl/output_accum_pipe.sv
// output_accum_pipe
//   Output pipeline: fetches NUM_PORTS scratchpad words per cycle, reduces every
//   lane of every port into one signed accumulator per result, packs LANES
//   finished results into an output word and writes it to output memory.
//   A partial word (unused lanes zero) is flushed at the end of a job.
//
// Ports
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   start               1-cycle job request, sampled only while idle
//   cfg_len             scratchpad words per port summed into one result
//   cfg_count           number of results in the job
//   cfg_rd_base         read base address per port (port p at [p*ADDR_W +: ADDR_W])
//   cfg_out_base        first output address
//   sp_read_en          read strobe, data returns on sp_read_bus next cycle
//   sp_read_addr        read address per port
//   sp_read_bus         read data, lane l of port p at [(p*LANES+l)*DATA_W +: DATA_W]
//   out_we              output write strobe, one cycle per word
//   out_bus, out_addr   packed results (result k at lane k) and output address
//   busy                high from the cycle after an accepted start until done
//   done                one-cycle pulse at end of job
module output_accum_pipe #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 8,
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 8,
  parameter bit SAT       = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [LEN_W-1:0]                  cfg_len,
  input  logic [LEN_W-1:0]                  cfg_count,
  input  logic [NUM_PORTS*ADDR_W-1:0]       cfg_rd_base,
  input  logic [ADDR_W-1:0]                 cfg_out_base,
  output logic                              sp_read_en,
  output logic [NUM_PORTS*ADDR_W-1:0]       sp_read_addr,
  input  logic [NUM_PORTS*LANES*DATA_W-1:0] sp_read_bus,
  output logic                              out_we,
  output logic [LANES*DATA_W-1:0]           out_bus,
  output logic [ADDR_W-1:0]                 out_addr,
  output logic                              busy,
  output logic                              done
);

  localparam int NUM_TERMS = NUM_PORTS * LANES;
  localparam int SUM_W     = DATA_W + $clog2(NUM_TERMS);
  localparam int ACC_W     = SUM_W + LEN_W;
  localparam int CNT_W     = (LANES > 1) ? $clog2(LANES) : 1;

  // Clamp bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0]            len_q, count_q;
  logic [NUM_PORTS*ADDR_W-1:0] rd_base_q;
  logic [ADDR_W-1:0]           out_base_q;
  logic [ADDR_W-1:0]           idx_q;
  logic [LEN_W-1:0]            word_cnt, res_cnt;
  logic [ADDR_W-1:0]           words_written;
  logic [CNT_W-1:0]            store_cnt;
  logic [LANES*DATA_W-1:0]     pack_q, pack_next;
  logic                        vld_q, first_q, last_q;
  logic signed [ACC_W-1:0]     acc_q, acc_base, acc_next;
  logic signed [SUM_W-1:0]     term;
  logic [DATA_W-1:0]           result;
  logic                        fetching, last_issue, pack_full;
  logic [LEN_W-1:0]            len_last, count_last;

  assign len_last   = len_q - LEN_W'(1);
  assign count_last = count_q - LEN_W'(1);
  assign last_issue = (word_cnt == len_last) && (res_cnt == count_last);
  assign pack_full  = (store_cnt == CNT_W'(LANES - 1));

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and state-decoded outputs. FLUSH repeats once when a partial
  // word is pending: the first pass writes it, the second raises done.
  always_comb begin
    state_d    = state_q;
    fetching   = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && (cfg_len != '0) && (cfg_count != '0)) state_d = FETCH;
      end
      FETCH: begin
        fetching = 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN:   state_d = FLUSH;
      FLUSH:   if (store_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sp_read_en = fetching;
  end

  // Per-port read address; held at zero outside FETCH.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_addr
    assign sp_read_addr[p*ADDR_W +: ADDR_W] =
      fetching ? rd_base_q[p*ADDR_W +: ADDR_W] + idx_q : '0;
  end

  // Sign-extended sum of every lane of every port returned this cycle.
  always_comb begin
    logic signed [DATA_W-1:0] lane_v;
    term = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      lane_v = sp_read_bus[i*DATA_W +: DATA_W];
      term   = term + SUM_W'(lane_v);
    end
  end

  // Accumulate, then clamp or wrap the finished value to DATA_W.
  always_comb begin
    acc_base = first_q ? '0 : acc_q;
    acc_next = acc_base + ACC_W'(term);
    result   = acc_next[DATA_W-1:0];
    if (SAT) begin
      if (acc_next > MAX_V)      result = MAX_V[DATA_W-1:0];
      else if (acc_next < MIN_V) result = MIN_V[DATA_W-1:0];
    end
  end

  // Pack register with the current result dropped into lane store_cnt.
  always_comb begin
    pack_next = pack_q;
    for (int k = 0; k < LANES; k++) begin
      if (store_cnt == CNT_W'(k)) pack_next[k*DATA_W +: DATA_W] = result;
    end
  end

  // Datapath: config latch, issue counters, read-return pipeline flags,
  // accumulator, packing and output writes. A word is written the cycle after
  // the data cycle that completes it, so a job whose last result fills a word
  // reaches FLUSH with nothing left to write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q         <= '0;
      count_q       <= '0;
      rd_base_q     <= '0;
      out_base_q    <= '0;
      idx_q         <= '0;
      word_cnt      <= '0;
      res_cnt       <= '0;
      words_written <= '0;
      store_cnt     <= '0;
      pack_q        <= '0;
      vld_q         <= 1'b0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      acc_q         <= '0;
      out_we        <= 1'b0;
      out_bus       <= '0;
      out_addr      <= '0;
      done          <= 1'b0;
    end else begin
      out_we  <= 1'b0;
      done    <= 1'b0;
      vld_q   <= fetching;
      first_q <= fetching && (word_cnt == '0);
      last_q  <= fetching && (word_cnt == len_last);
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q         <= cfg_len;
            count_q       <= cfg_count;
            rd_base_q     <= cfg_rd_base;
            out_base_q    <= cfg_out_base;
            idx_q         <= '0;
            word_cnt      <= '0;
            res_cnt       <= '0;
            words_written <= '0;
            store_cnt     <= '0;
            pack_q        <= '0;
            if ((cfg_len == '0) || (cfg_count == '0)) done <= 1'b1;
          end
        end
        FETCH: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (word_cnt == len_last) begin
            word_cnt <= '0;
            res_cnt  <= res_cnt + LEN_W'(1);
          end else begin
            word_cnt <= word_cnt + LEN_W'(1);
          end
        end
        FLUSH: begin
          if (store_cnt != '0) begin
            out_we        <= 1'b1;
            out_bus       <= pack_q;
            out_addr      <= out_base_q + words_written;
            words_written <= words_written + ADDR_W'(1);
            pack_q        <= '0;
            store_cnt     <= '0;
          end else begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
      if (vld_q) begin
        acc_q <= acc_next;
        if (last_q) begin
          if (pack_full) begin
            out_we        <= 1'b1;
            out_bus       <= pack_next;
            out_addr      <= out_base_q + words_written;
            words_written <= words_written + ADDR_W'(1);
            pack_q        <= '0;
            store_cnt     <= '0;
          end else begin
            pack_q    <= pack_next;
            store_cnt <= store_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_output_accum_pipe.sv
// tb_output_accum_pipe
//   Self-checking bench for output_accum_pipe. Two instances share every input:
//   one saturating, one wrapping. A scoreboard of expected read addresses and
//   expected output writes is built from a reference sum of the lane data, and
//   compared against what the instances produce during each job.
module tb_output_accum_pipe;

  localparam int DATA_W    = 16;
  localparam int LANES     = 8;
  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 16;
  localparam int LEN_W     = 8;
  localparam int RD_W      = NUM_PORTS * ADDR_W;
  localparam int WR_W      = ADDR_W + LANES * DATA_W;

  logic                              clock = 1'b0;
  logic                              reset_n, start;
  logic [LEN_W-1:0]                  cfg_len, cfg_count;
  logic [RD_W-1:0]                   cfg_rd_base;
  logic [ADDR_W-1:0]                 cfg_out_base;
  logic [NUM_PORTS*LANES*DATA_W-1:0] sp_read_bus;

  logic                    sp_read_en, out_we, busy, done;
  logic [RD_W-1:0]         sp_read_addr;
  logic [LANES*DATA_W-1:0] out_bus;
  logic [ADDR_W-1:0]       out_addr;

  logic                    w_sp_read_en, w_out_we, w_busy, w_done;
  logic [RD_W-1:0]         w_sp_read_addr;
  logic [LANES*DATA_W-1:0] w_out_bus;
  logic [ADDR_W-1:0]       w_out_addr;

  output_accum_pipe #(.DATA_W(DATA_W), .LANES(LANES), .NUM_PORTS(NUM_PORTS),
                      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .SAT(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .cfg_len(cfg_len),
    .cfg_count(cfg_count), .cfg_rd_base(cfg_rd_base), .cfg_out_base(cfg_out_base),
    .sp_read_en(sp_read_en), .sp_read_addr(sp_read_addr), .sp_read_bus(sp_read_bus),
    .out_we(out_we), .out_bus(out_bus), .out_addr(out_addr), .busy(busy), .done(done));

  output_accum_pipe #(.DATA_W(DATA_W), .LANES(LANES), .NUM_PORTS(NUM_PORTS),
                      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .SAT(1'b0)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .start(start), .cfg_len(cfg_len),
    .cfg_count(cfg_count), .cfg_rd_base(cfg_rd_base), .cfg_out_base(cfg_out_base),
    .sp_read_en(w_sp_read_en), .sp_read_addr(w_sp_read_addr), .sp_read_bus(sp_read_bus),
    .out_we(w_out_we), .out_bus(w_out_bus), .out_addr(w_out_addr), .busy(w_busy), .done(w_done));

  always #5 clock = ~clock;

  int checks_total  = 0;
  int checks_passed = 0;

  // Scratchpad data model: constant fill or an address-dependent signed pattern.
  int                data_mode = 0;
  logic [DATA_W-1:0] fill_val  = '0;

  function automatic logic [DATA_W-1:0] lane_value(int p, int l, logic [ADDR_W-1:0] a);
    int v;
    if (data_mode == 0) return fill_val;
    v = int'(a[5:0]) * 3 - 50 + l * 7 - p * 11;
    return DATA_W'(v);
  endfunction

  // Scratchpad responder: address seen during a read cycle, data driven just
  // after the closing edge so it is valid throughout the following cycle.
  always begin
    logic            en_s;
    logic [RD_W-1:0] addr_s;
    @(negedge clock);
    en_s   = sp_read_en;
    addr_s = sp_read_addr;
    @(posedge clock);
    #1;
    if (en_s) begin
      for (int p = 0; p < NUM_PORTS; p++)
        for (int l = 0; l < LANES; l++)
          sp_read_bus[(p*LANES+l)*DATA_W +: DATA_W] = lane_value(p, l, addr_s[p*ADDR_W +: ADDR_W]);
    end
  end

  // Scoreboard queues and per-job observations.
  logic [RD_W-1:0] exp_rd[$], obs_rd[$];
  logic [WR_W-1:0] exp_wr[$], obs_wr[$], exp_wr_w[$], obs_wr_w[$];
  int  exp_lat, exp_busy;
  int  obs_done, obs_w_done, obs_done_k, obs_busy;
  bit  obs_timeout;
  logic [RD_W-1:0] e_rd, o_rd;
  logic [WR_W-1:0] e_wr, o_wr;

  // Reference model: read addresses in issue order, lane sums per result,
  // saturated and wrapped packed words, done latency and busy length.
  task automatic applyStimulus_build(input int len, input int count,
                                     input logic [RD_W-1:0] base, input logic [ADDR_W-1:0] ob);
    logic [LANES*DATA_W-1:0] word_s, word_w;
    logic [RD_W-1:0]         av;
    logic [DATA_W-1:0]       s;
    longint                  acc;
    int                      lane, nw;
    exp_rd.delete(); exp_wr.delete(); exp_wr_w.delete();
    word_s = '0; word_w = '0; lane = 0; nw = 0;
    for (int r = 0; r < count; r++) begin
      acc = 0;
      for (int w = 0; w < len; w++) begin
        for (int p = 0; p < NUM_PORTS; p++)
          av[p*ADDR_W +: ADDR_W] = base[p*ADDR_W +: ADDR_W] + ADDR_W'(r * len + w);
        exp_rd.push_back(av);
        for (int p = 0; p < NUM_PORTS; p++)
          for (int l = 0; l < LANES; l++)
            acc += longint'(signed'(lane_value(p, l, av[p*ADDR_W +: ADDR_W])));
      end
      if (acc > 32767)       s = 16'h7FFF;
      else if (acc < -32768) s = 16'h8000;
      else                   s = acc[DATA_W-1:0];
      word_s[lane*DATA_W +: DATA_W] = s;
      word_w[lane*DATA_W +: DATA_W] = acc[DATA_W-1:0];
      lane++;
      if (lane == LANES) begin
        exp_wr.push_back({ob + ADDR_W'(nw), word_s});
        exp_wr_w.push_back({ob + ADDR_W'(nw), word_w});
        nw++; lane = 0; word_s = '0; word_w = '0;
      end
    end
    if (lane != 0) begin
      exp_wr.push_back({ob + ADDR_W'(nw), word_s});
      exp_wr_w.push_back({ob + ADDR_W'(nw), word_w});
    end
    if (len == 0 || count == 0) begin
      exp_lat = 1; exp_busy = 0;
    end else begin
      exp_lat  = len * count + 3 + ((lane != 0) ? 1 : 0);
      exp_busy = len * count + 2 + ((lane != 0) ? 1 : 0);
    end
  endtask

  // Runs one job and records everything the two instances do. glitch_at > 0
  // pulses start with a different config twice while the job is running.
  task automatic applyStimulus_job(input int len, input int count, input logic [RD_W-1:0] base,
                                   input logic [ADDR_W-1:0] ob, input int glitch_at);
    int  limit;
    bit  finished;
    obs_rd.delete(); obs_wr.delete(); obs_wr_w.delete();
    obs_done = 0; obs_w_done = 0; obs_done_k = -1; obs_busy = 0; obs_timeout = 0;
    finished = 0;
    limit = len * count + 30;
    @(negedge clock);
    cfg_len = LEN_W'(len); cfg_count = LEN_W'(count); cfg_rd_base = base; cfg_out_base = ob;
    start = 1'b1;
    @(negedge clock);
    for (int k = 1; k <= limit && !finished; k++) begin
      if (k > 1) @(negedge clock);
      if (sp_read_en) obs_rd.push_back(sp_read_addr);
      if (out_we)     obs_wr.push_back({out_addr, out_bus});
      if (w_out_we)   obs_wr_w.push_back({w_out_addr, w_out_bus});
      if (busy)       obs_busy++;
      if (w_done)     obs_w_done++;
      if (done) begin
        obs_done++;
        if (obs_done_k < 0) obs_done_k = k;
      end
      start = 1'b0;
      if (glitch_at > 0 && (k == glitch_at || k == glitch_at + 3)) begin
        start = 1'b1; cfg_len = 8'd1; cfg_count = 8'd1;
        cfg_rd_base = '0; cfg_out_base = 16'hDEAD;
      end
      if (obs_done_k >= 0 && k >= obs_done_k + 3) finished = 1;
    end
    start = 1'b0;
    if (obs_done_k < 0) obs_timeout = 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks_total++;
    if ({sp_read_en, sp_read_addr, out_we, out_bus, out_addr, busy, done} !== '0)
      $display("[TB] FAIL reset_outputs: got en=%b we=%b busy=%b done=%b addr=%h, expected all zero",
               sp_read_en, out_we, busy, done, out_addr);
    else checks_passed++;
    checks_total++;
    if ({w_sp_read_en, w_out_we, w_out_bus, w_out_addr, w_busy, w_done} !== '0)
      $display("[TB] FAIL reset_outputs_wrap: got we=%b busy=%b done=%b, expected all zero",
               w_out_we, w_busy, w_done);
    else checks_passed++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_full_word();
    string tag = "full";
    data_mode = 0; fill_val = 16'd1;
    applyStimulus_build(1, 8, {16'h0200, 16'h0100}, 16'h0040);
    applyStimulus_job(1, 8, {16'h0200, 16'h0100}, 16'h0040, 0);
    checks_total++;
    if (obs_timeout) $display("[TB] FAIL %s_timeout: done not seen, expected at cycle %0d", tag, exp_lat); else checks_passed++;
    checks_total++;
    if (obs_rd.size() != exp_rd.size()) $display("[TB] FAIL %s_rd_count: got %0d expected %0d", tag, obs_rd.size(), exp_rd.size()); else checks_passed++;
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      e_rd = exp_rd.pop_front(); o_rd = obs_rd.pop_front(); checks_total++;
      if (o_rd !== e_rd) $display("[TB] FAIL %s_rd_addr: got %h expected %h", tag, o_rd, e_rd); else checks_passed++;
    end
    checks_total++;
    if (obs_wr.size() != exp_wr.size()) $display("[TB] FAIL %s_wr_count: got %0d expected %0d", tag, obs_wr.size(), exp_wr.size()); else checks_passed++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e_wr = exp_wr.pop_front(); o_wr = obs_wr.pop_front(); checks_total++;
      if (o_wr !== e_wr) $display("[TB] FAIL %s_wr: got %h expected %h", tag, o_wr, e_wr); else checks_passed++;
    end
    checks_total++;
    if (obs_done != 1 || obs_done_k != exp_lat) $display("[TB] FAIL %s_done: got %0d pulses at cycle %0d expected 1 at %0d", tag, obs_done, obs_done_k, exp_lat); else checks_passed++;
    checks_total++;
    if (obs_busy != exp_busy) $display("[TB] FAIL %s_busy_len: got %0d expected %0d", tag, obs_busy, exp_busy); else checks_passed++;
  endtask

  task automatic test_partial();
    string tag = "partial";
    data_mode = 0; fill_val = 16'd1;
    applyStimulus_build(4, 3, {16'h1000, 16'h0500}, 16'h0080);
    applyStimulus_job(4, 3, {16'h1000, 16'h0500}, 16'h0080, 0);
    checks_total++;
    if (obs_timeout) $display("[TB] FAIL %s_timeout: done not seen, expected at cycle %0d", tag, exp_lat); else checks_passed++;
    checks_total++;
    if (obs_rd.size() != exp_rd.size()) $display("[TB] FAIL %s_rd_count: got %0d expected %0d", tag, obs_rd.size(), exp_rd.size()); else checks_passed++;
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      e_rd = exp_rd.pop_front(); o_rd = obs_rd.pop_front(); checks_total++;
      if (o_rd !== e_rd) $display("[TB] FAIL %s_rd_addr: got %h expected %h", tag, o_rd, e_rd); else checks_passed++;
    end
    checks_total++;
    if (obs_wr.size() != exp_wr.size()) $display("[TB] FAIL %s_wr_count: got %0d expected %0d", tag, obs_wr.size(), exp_wr.size()); else checks_passed++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e_wr = exp_wr.pop_front(); o_wr = obs_wr.pop_front(); checks_total++;
      if (o_wr !== e_wr) $display("[TB] FAIL %s_wr: got %h expected %h", tag, o_wr, e_wr); else checks_passed++;
    end
    checks_total++;
    if (obs_done != 1 || obs_done_k != exp_lat) $display("[TB] FAIL %s_done: got %0d pulses at cycle %0d expected 1 at %0d", tag, obs_done, obs_done_k, exp_lat); else checks_passed++;
    checks_total++;
    if (obs_busy != exp_busy) $display("[TB] FAIL %s_busy_len: got %0d expected %0d", tag, obs_busy, exp_busy); else checks_passed++;
  endtask

  task automatic test_saturation();
    string tag = "sat";
    logic [DATA_W-1:0] fills [2] = '{16'h7FFF, 16'h8000};
    for (int f = 0; f < 2; f++) begin
      data_mode = 0; fill_val = fills[f];
      applyStimulus_build(2, 1, {16'h0030, 16'h0020}, 16'h0010);
      applyStimulus_job(2, 1, {16'h0030, 16'h0020}, 16'h0010, 0);
      checks_total++;
      if (obs_timeout) $display("[TB] FAIL %s_timeout: done not seen, expected at cycle %0d", tag, exp_lat); else checks_passed++;
      checks_total++;
      if (obs_wr.size() != exp_wr.size()) $display("[TB] FAIL %s_wr_count: got %0d expected %0d", tag, obs_wr.size(), exp_wr.size()); else checks_passed++;
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
        e_wr = exp_wr.pop_front(); o_wr = obs_wr.pop_front(); checks_total++;
        if (o_wr !== e_wr) $display("[TB] FAIL %s_wr_clamped: got %h expected %h", tag, o_wr, e_wr); else checks_passed++;
      end
      checks_total++;
      if (obs_wr_w.size() != exp_wr_w.size()) $display("[TB] FAIL %s_wrap_wr_count: got %0d expected %0d", tag, obs_wr_w.size(), exp_wr_w.size()); else checks_passed++;
      while (exp_wr_w.size() > 0 && obs_wr_w.size() > 0) begin
        e_wr = exp_wr_w.pop_front(); o_wr = obs_wr_w.pop_front(); checks_total++;
        if (o_wr !== e_wr) $display("[TB] FAIL %s_wr_wrapped: got %h expected %h", tag, o_wr, e_wr); else checks_passed++;
      end
      checks_total++;
      if (obs_done != 1 || obs_w_done != 1 || obs_done_k != exp_lat) $display("[TB] FAIL %s_done: got %0d/%0d pulses at cycle %0d expected 1/1 at %0d", tag, obs_done, obs_w_done, obs_done_k, exp_lat); else checks_passed++;
    end
  endtask

  task automatic test_zero_count();
    string tag = "zero";
    data_mode = 0; fill_val = 16'd5;
    applyStimulus_build(3, 0, {16'h0700, 16'h0600}, 16'h0090);
    applyStimulus_job(3, 0, {16'h0700, 16'h0600}, 16'h0090, 0);
    checks_total++;
    if (obs_done != 1 || obs_done_k != exp_lat) $display("[TB] FAIL %s_done: got %0d pulses at cycle %0d expected 1 at %0d", tag, obs_done, obs_done_k, exp_lat); else checks_passed++;
    checks_total++;
    if (obs_rd.size() != 0) $display("[TB] FAIL %s_reads: got %0d expected 0", tag, obs_rd.size()); else checks_passed++;
    checks_total++;
    if (obs_wr.size() != 0) $display("[TB] FAIL %s_writes: got %0d expected 0", tag, obs_wr.size()); else checks_passed++;
    checks_total++;
    if (obs_busy != 0) $display("[TB] FAIL %s_busy: got %0d busy cycles expected 0", tag, obs_busy); else checks_passed++;
  endtask

  task automatic test_busy_start();
    string tag = "busy_start";
    data_mode = 1;
    applyStimulus_build(3, 11, {16'h0140, 16'h0017}, 16'h0200);
    applyStimulus_job(3, 11, {16'h0140, 16'h0017}, 16'h0200, 4);
    checks_total++;
    if (obs_timeout) $display("[TB] FAIL %s_timeout: done not seen, expected at cycle %0d", tag, exp_lat); else checks_passed++;
    checks_total++;
    if (obs_rd.size() != exp_rd.size()) $display("[TB] FAIL %s_rd_count: got %0d expected %0d", tag, obs_rd.size(), exp_rd.size()); else checks_passed++;
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      e_rd = exp_rd.pop_front(); o_rd = obs_rd.pop_front(); checks_total++;
      if (o_rd !== e_rd) $display("[TB] FAIL %s_rd_addr: got %h expected %h", tag, o_rd, e_rd); else checks_passed++;
    end
    checks_total++;
    if (obs_wr.size() != exp_wr.size()) $display("[TB] FAIL %s_wr_count: got %0d expected %0d", tag, obs_wr.size(), exp_wr.size()); else checks_passed++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e_wr = exp_wr.pop_front(); o_wr = obs_wr.pop_front(); checks_total++;
      if (o_wr !== e_wr) $display("[TB] FAIL %s_wr: got %h expected %h", tag, o_wr, e_wr); else checks_passed++;
    end
    while (exp_wr_w.size() > 0 && obs_wr_w.size() > 0) begin
      e_wr = exp_wr_w.pop_front(); o_wr = obs_wr_w.pop_front(); checks_total++;
      if (o_wr !== e_wr) $display("[TB] FAIL %s_wrap_wr: got %h expected %h", tag, o_wr, e_wr); else checks_passed++;
    end
    checks_total++;
    if (obs_done != 1 || obs_done_k != exp_lat) $display("[TB] FAIL %s_done: got %0d pulses at cycle %0d expected 1 at %0d", tag, obs_done, obs_done_k, exp_lat); else checks_passed++;
  endtask

  task automatic test_reset_abort();
    string tag = "abort";
    data_mode = 0; fill_val = 16'd3;
    @(negedge clock);
    cfg_len = 8'd4; cfg_count = 8'd4; cfg_rd_base = {16'h0900, 16'h0800}; cfg_out_base = 16'h0777;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks_total++;
    if (sp_read_en !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL %s_mid_fetch: got en=%b busy=%b expected 1 1", tag, sp_read_en, busy); else checks_passed++;
    reset_n = 1'b0;
    #1;
    checks_total++;
    if ({sp_read_en, sp_read_addr, out_we, out_bus, out_addr, busy, done} !== '0)
      $display("[TB] FAIL %s_async_clear: got en=%b we=%b busy=%b done=%b, expected all zero", tag, sp_read_en, out_we, busy, done);
    else checks_passed++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks_total++;
    if ({sp_read_en, out_we, busy, done} !== 4'b0000) $display("[TB] FAIL %s_idle_after: got en=%b we=%b busy=%b done=%b expected 0000", tag, sp_read_en, out_we, busy, done); else checks_passed++;
    fill_val = 16'd2;
    applyStimulus_build(1, 8, {16'h0010, 16'h0000}, 16'h0300);
    applyStimulus_job(1, 8, {16'h0010, 16'h0000}, 16'h0300, 0);
    checks_total++;
    if (obs_wr.size() != exp_wr.size()) $display("[TB] FAIL %s_wr_count: got %0d expected %0d", tag, obs_wr.size(), exp_wr.size()); else checks_passed++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e_wr = exp_wr.pop_front(); o_wr = obs_wr.pop_front(); checks_total++;
      if (o_wr !== e_wr) $display("[TB] FAIL %s_wr_after: got %h expected %h", tag, o_wr, e_wr); else checks_passed++;
    end
    checks_total++;
    if (obs_done != 1 || obs_done_k != exp_lat) $display("[TB] FAIL %s_done: got %0d pulses at cycle %0d expected 1 at %0d", tag, obs_done, obs_done_k, exp_lat); else checks_passed++;
  endtask

  task automatic test_wrap();
    string tag = "wrap";
    data_mode = 1;
    applyStimulus_build(1, 16, {16'hFFF8, 16'hFFFE}, 16'hFFFF);
    applyStimulus_job(1, 16, {16'hFFF8, 16'hFFFE}, 16'hFFFF, 0);
    checks_total++;
    if (obs_timeout) $display("[TB] FAIL %s_timeout: done not seen, expected at cycle %0d", tag, exp_lat); else checks_passed++;
    checks_total++;
    if (obs_rd.size() != exp_rd.size()) $display("[TB] FAIL %s_rd_count: got %0d expected %0d", tag, obs_rd.size(), exp_rd.size()); else checks_passed++;
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      e_rd = exp_rd.pop_front(); o_rd = obs_rd.pop_front(); checks_total++;
      if (o_rd !== e_rd) $display("[TB] FAIL %s_rd_addr: got %h expected %h", tag, o_rd, e_rd); else checks_passed++;
    end
    checks_total++;
    if (obs_wr.size() != exp_wr.size()) $display("[TB] FAIL %s_wr_count: got %0d expected %0d", tag, obs_wr.size(), exp_wr.size()); else checks_passed++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e_wr = exp_wr.pop_front(); o_wr = obs_wr.pop_front(); checks_total++;
      if (o_wr !== e_wr) $display("[TB] FAIL %s_wr: got %h expected %h", tag, o_wr, e_wr); else checks_passed++;
    end
    checks_total++;
    if (obs_done != 1 || obs_done_k != exp_lat) $display("[TB] FAIL %s_done: got %0d pulses at cycle %0d expected 1 at %0d", tag, obs_done, obs_done_k, exp_lat); else checks_passed++;
    checks_total++;
    if (obs_busy != exp_busy) $display("[TB] FAIL %s_busy_len: got %0d expected %0d", tag, obs_busy, exp_busy); else checks_passed++;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0;
    cfg_len = '0; cfg_count = '0; cfg_rd_base = '0; cfg_out_base = '0;
    sp_read_bus = '0;
    test_reset();
    test_full_word();
    test_partial();
    test_saturation();
    test_zero_count();
    test_busy_start();
    test_reset_abort();
    test_wrap();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
